alu_exec: RTL

Sequential execute unit directly downstream of the ALU control decoder: it consumes the 4-bit operation code and the two register operands and returns a registered result and zero flag. Logic/arithmetic ops complete in one cycle. Multiply runs iteratively (shift-add) over WIDTH cycles. A start/busy/done handshake lets the processor stall its PC while a multiply is in flight.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_exec_if.sv | 24 ++
 rtl/mul_shift_add.sv | 58 +++++
 rtl/alu_exec.sv | 97 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the execute unit.
// Op codes live here only, so decoder and execute unit cannot disagree.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/response bundle between the processor pipeline and alu_exec.
// start is only honoured while busy is low; done pulses once per completed op.
interface alu_exec_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, operation, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, operation, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier datapath, one partial product per step.
// product already includes the current step's add, so the final step can be captured directly.
module mul_shift_add #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] product,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = acc_step;
  assign last     = (count_q == CW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (load) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      count_d  = '0;
    end else if (step) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// Execute unit: logic/add/sub in 1 cycle, MUL over WIDTH cycles with busy held high.
// start is ignored while busy; outputs are all registered and held until the next done.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] single_res;
  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] mul_product;
  logic             mul_last;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .product (mul_product),
    .last    (mul_last)
  );

  // Unknown codes fall through to zero rather than trapping.
  always_comb begin
    single_res = '0;
    case (bus.operation)
      OP_AND:  single_res = bus.a & bus.b;
      OP_OR:   single_res = bus.a | bus.b;
      OP_ADD:  single_res = bus.a + bus.b;
      OP_SUB:  single_res = bus.a - bus.b;
      OP_XOR:  single_res = bus.a ^ bus.b;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_product;
          zero_d   = (mul_product == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == S_MUL);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule
